// File: rtl/calc_input_ctrl_if.sv
// Operation handshake between the input controller and the calculator datapath.
// The master offers a one-hot operation plus operands; the slave answers with op_ready.
interface calc_input_ctrl_if;
    logic [3:0] button;
    logic [3:0] switch_x;
    logic [3:0] switch_y;
    logic       op_valid;
    logic       op_ready;

    modport master (
        output button,
        output switch_x,
        output switch_y,
        output op_valid,
        input  op_ready
    );

    modport slave (
        input  button,
        input  switch_x,
        input  switch_y,
        input  op_valid,
        output op_ready
    );
endinterface

// File: rtl/calc_input_ctrl.sv
// Button synchronizer/debouncer and one-hot operation offer for the 4-bit calculator.
// Optional macro CALC_IN_SWITCH_SYNC_EN adds 2-flop synchronizers on both operand switch banks.
module calc_input_ctrl #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [3:0]               button_raw,
    input  logic [3:0]               switch_x_raw,
    input  logic [3:0]               switch_y_raw,
    calc_input_ctrl_if.master        op_if
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_HOLD    = 2'd1;
    localparam logic [1:0] ST_RELEASE = 2'd2;

    logic [3:0]       btn_meta_q,  btn_meta_d;
    logic [3:0]       btn_sync_q,  btn_sync_d;
    logic [3:0]       deb_q,       deb_d;
    logic [3:0]       deb_prev_q,  deb_prev_d;
    logic [CNT_W-1:0] cnt_q [4];
    logic [CNT_W-1:0] cnt_d [4];

    logic [1:0]       state_q,     state_d;
    logic [3:0]       button_q,    button_d;
    logic [3:0]       switch_x_q,  switch_x_d;
    logic [3:0]       switch_y_q,  switch_y_d;
    logic             op_valid_q,  op_valid_d;

    logic [3:0]       press;
    logic [3:0]       press_pick;
    logic [3:0]       cap_x;
    logic [3:0]       cap_y;

`ifdef CALC_IN_SWITCH_SYNC_EN
    logic [3:0] sx_meta_q, sx_meta_d;
    logic [3:0] sx_sync_q, sx_sync_d;
    logic [3:0] sy_meta_q, sy_meta_d;
    logic [3:0] sy_sync_q, sy_sync_d;

    always_comb begin
        sx_meta_d = switch_x_raw;
        sx_sync_d = sx_meta_q;
        sy_meta_d = switch_y_raw;
        sy_sync_d = sy_meta_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sx_meta_q <= '0;
            sx_sync_q <= '0;
            sy_meta_q <= '0;
            sy_sync_q <= '0;
        end else begin
            sx_meta_q <= sx_meta_d;
            sx_sync_q <= sx_sync_d;
            sy_meta_q <= sy_meta_d;
            sy_sync_q <= sy_sync_d;
        end
    end

    assign cap_x = sx_sync_q;
    assign cap_y = sy_sync_q;
`else
    assign cap_x = switch_x_raw;
    assign cap_y = switch_y_raw;
`endif

    always_comb begin
        btn_meta_d = button_raw;
        btn_sync_d = btn_meta_q;
        deb_prev_d = deb_q;
    end

    // The level only flips after the counter has already sat at CNT_MAX for one edge,
    // so a raw level must be stable for DEBOUNCE_CYCLES+1 synchronized samples.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            deb_d[i] = deb_q[i];
            cnt_d[i] = '0;
            if (btn_sync_q[i] != deb_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    deb_d[i] = ~deb_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    assign press = deb_q & ~deb_prev_q;

    always_comb begin
        press_pick = 4'b0000;
        if (press[0]) begin
            press_pick = 4'b0001;
        end else if (press[1]) begin
            press_pick = 4'b0010;
        end else if (press[2]) begin
            press_pick = 4'b0100;
        end else if (press[3]) begin
            press_pick = 4'b1000;
        end
    end

    // Offer one operation per press; the next one waits until every button is back up.
    always_comb begin
        state_d    = state_q;
        button_d   = button_q;
        switch_x_d = switch_x_q;
        switch_y_d = switch_y_q;
        op_valid_d = op_valid_q;
        case (state_q)
            ST_IDLE: begin
                if (press != 4'b0000) begin
                    button_d   = press_pick;
                    switch_x_d = cap_x;
                    switch_y_d = cap_y;
                    op_valid_d = 1'b1;
                    state_d    = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (op_valid_q && op_if.op_ready) begin
                    button_d   = 4'b0000;
                    op_valid_d = 1'b0;
                    state_d    = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                if (deb_q == 4'b0000) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                button_d   = 4'b0000;
                op_valid_d = 1'b0;
                state_d    = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            btn_meta_q <= '0;
            btn_sync_q <= '0;
            deb_q      <= '0;
            deb_prev_q <= '0;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= '0;
            end
            state_q    <= ST_IDLE;
            button_q   <= '0;
            switch_x_q <= '0;
            switch_y_q <= '0;
            op_valid_q <= 1'b0;
        end else begin
            btn_meta_q <= btn_meta_d;
            btn_sync_q <= btn_sync_d;
            deb_q      <= deb_d;
            deb_prev_q <= deb_prev_d;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            state_q    <= state_d;
            button_q   <= button_d;
            switch_x_q <= switch_x_d;
            switch_y_q <= switch_y_d;
            op_valid_q <= op_valid_d;
        end
    end

    assign op_if.button   = button_q;
    assign op_if.switch_x = switch_x_q;
    assign op_if.switch_y = switch_y_q;
    assign op_if.op_valid = op_valid_q;

endmodule

// File: tb/tb_calc_input_ctrl.sv
// Scoreboard bench for calc_input_ctrl with DEBOUNCE_CYCLES=4: stimulus pushes expected
// operations, a negedge monitor checks every offered and transferred operation.
module tb_calc_input_ctrl;

    localparam int DEB = 4;
    // Press first sampled at edge k, op_valid high after edge k+3+DEB: seen on poll number 8.
    localparam int EXP_LAT = 8;

    typedef struct {
        logic [3:0] b;
        logic [3:0] x;
        logic [3:0] y;
    } exp_t;

    logic       clk;
    logic       reset;
    logic [3:0] button_raw;
    logic [3:0] switch_x_raw;
    logic [3:0] switch_y_raw;

    calc_input_ctrl_if bus ();

    calc_input_ctrl #(.DEBOUNCE_CYCLES(DEB)) dut (
        .clk          (clk),
        .reset        (reset),
        .button_raw   (button_raw),
        .switch_x_raw (switch_x_raw),
        .switch_y_raw (switch_y_raw),
        .op_if        (bus)
    );

    exp_t exp_q[$];
    int   checks   = 0;
    int   errors   = 0;
    int   ops_done = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] btn, input logic [3:0] x,
                                 input logic [3:0] y, input logic rdy);
        button_raw   = btn;
        switch_x_raw = x;
        switch_y_raw = y;
        bus.op_ready = rdy;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pushExp(input logic [3:0] b, input logic [3:0] x, input logic [3:0] y);
        exp_t e;
        e.b = b;
        e.x = x;
        e.y = y;
        exp_q.push_back(e);
    endtask

    task automatic waitValid(input string name, input int expected_lat);
        int n;
        n = 0;
        while (n < 40) begin
            @(posedge clk);
            #1;
            n++;
            if (bus.op_valid) break;
        end
        if (!bus.op_valid) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s: op_valid never rose within %0d cycles, expected %0d", name, n, expected_lat);
        end else begin
            checkOutput(name, n, expected_lat);
        end
    endtask

    task automatic waitOps(input string name, input int target);
        int n;
        n = 0;
        while (ops_done < target && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput(name, ops_done, target);
    endtask

    // Monitor: every offered operation must match the scoreboard head; a transfer pops it.
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.op_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_op: got button %0h, expected no operation", bus.button);
                end else begin
                    checkOutput("mon_button", bus.button,   exp_q[0].b);
                    checkOutput("mon_x",      bus.switch_x, exp_q[0].x);
                    checkOutput("mon_y",      bus.switch_y, exp_q[0].y);
                    if (bus.op_ready) begin
                        void'(exp_q.pop_front());
                        ops_done++;
                    end
                end
            end else begin
                checkOutput("mon_button_idle", bus.button, 4'b0000);
            end
        end
    end

    initial begin
        int base;
        reset = 1'b1;
        applyStimulus(4'b1111, 4'b1010, 4'b0101, 1'b1);
        idle(1);
        applyStimulus(4'b0101, 4'b0110, 4'b1001, 1'b0);
        idle(1);
        applyStimulus(4'b0000, 4'b0000, 4'b0000, 1'b0);
        checkOutput("rst_button", bus.button,   4'b0000);
        checkOutput("rst_x",      bus.switch_x, 4'b0000);
        checkOutput("rst_y",      bus.switch_y, 4'b0000);
        checkOutput("rst_valid",  bus.op_valid, 1'b0);
        reset = 1'b0;
        idle(3);

        $display("[TB] single press");
        applyStimulus(4'b0001, 4'b0011, 4'b0101, 1'b1);
        pushExp(4'b0001, 4'd3, 4'd5);
        waitValid("single_latency", EXP_LAT);
        idle(1);
        checkOutput("single_pulse_valid", bus.op_valid, 1'b0);
        checkOutput("single_ops", ops_done, 1);
        applyStimulus(4'b0000, 4'b0011, 4'b0101, 1'b1);
        idle(12);

        $display("[TB] backpressure");
        applyStimulus(4'b0100, 4'b1001, 4'b0110, 1'b0);
        pushExp(4'b0100, 4'b1001, 4'b0110);
        waitValid("bp_latency", EXP_LAT);
        applyStimulus(4'b0100, 4'b1111, 4'b1111, 1'b0);
        idle(20);
        checkOutput("bp_still_valid", bus.op_valid, 1'b1);
        checkOutput("bp_no_transfer", ops_done, 1);
        bus.op_ready = 1'b1;
        idle(1);
        checkOutput("bp_transfer", ops_done, 2);
        checkOutput("bp_valid_drop", bus.op_valid, 1'b0);
        applyStimulus(4'b0000, 4'b1111, 4'b1111, 1'b1);
        idle(12);

        $display("[TB] glitch and bounce");
        applyStimulus(4'b0010, 4'b0001, 4'b1000, 1'b1);
        idle(3);
        button_raw = 4'b0000;
        idle(10);
        checkOutput("glitch_no_op", ops_done, 2);
        pushExp(4'b0010, 4'b0001, 4'b1000);
        for (int i = 0; i < 10; i++) begin
            button_raw = (i % 2 == 0) ? 4'b0010 : 4'b0000;
            idle(1);
        end
        button_raw = 4'b0010;
        waitOps("bounce_one_op", 3);
        idle(5);
        checkOutput("bounce_single", ops_done, 3);
        button_raw = 4'b0000;
        idle(12);

        $display("[TB] simultaneous press");
        applyStimulus(4'b1010, 4'b0111, 4'b0010, 1'b1);
        pushExp(4'b0010, 4'b0111, 4'b0010);
        waitOps("simul_first", 4);
        idle(20);
        checkOutput("simul_no_second", ops_done, 4);
        button_raw = 4'b0000;
        idle(12);
        button_raw = 4'b1010;
        pushExp(4'b0010, 4'b0111, 4'b0010);
        waitOps("simul_repress", 5);
        button_raw = 4'b0000;
        idle(12);

        $display("[TB] reset during hold");
        applyStimulus(4'b0001, 4'b0111, 4'b1000, 1'b0);
        pushExp(4'b0001, 4'b0111, 4'b1000);
        waitValid("hold_latency", EXP_LAT);
        idle(2);
        checkOutput("hold_valid", bus.op_valid, 1'b1);
        base = ops_done;
        reset = 1'b1;
        button_raw = 4'b0000;
        idle(1);
        reset = 1'b0;
        exp_q.delete();
        checkOutput("hold_reset_valid", bus.op_valid, 1'b0);
        bus.op_ready = 1'b1;
        idle(20);
        checkOutput("hold_reset_no_transfer", ops_done, base);

        checkOutput("sb_empty", exp_q.size(), 0);
        checkOutput("total_ops", ops_done, 5);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
